// File: rtl/set_assoc_cache_ctrl_if.sv
// CPU-side load/store bus and RAM-side bus of the set-associative cache controller.
// The controller takes the slave modport; the CPU/RAM environment takes the master modport.
interface set_assoc_cache_ctrl_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ready;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_data;
  logic              hit;
  logic              miss;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic [CNT_W-1:0]  hit_count;
  logic [CNT_W-1:0]  miss_count;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_ack, mem_rdata,
    output cpu_ready, resp_valid, resp_data, hit, miss,
           mem_req, mem_we, mem_addr, mem_wdata, hit_count, miss_count
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_ack, mem_rdata,
    input  cpu_ready, resp_valid, resp_data, hit, miss,
           mem_req, mem_we, mem_addr, mem_wdata, hit_count, miss_count
  );
endinterface

// File: rtl/set_assoc_cache_ctrl.sv
// N-way set-associative, write-through/write-allocate cache controller with per-set FIFO
// replacement, req/ack handshakes on both sides and saturating hit/miss counters.
module set_assoc_cache_ctrl #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8,
  parameter int SETS   = 4,
  parameter int WAYS   = 4,
  parameter int CNT_W  = 16
) (
  input logic                  clk,
  input logic                  reset,
  set_assoc_cache_ctrl_if.slave bus
);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - IDX_W;
  localparam int WAY_W = $clog2(WAYS);

  typedef enum logic [1:0] {IDLE, LOOKUP, MEM, RESP} state_t;

  state_t            state_reg, state_next;
  logic              we_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic [DATA_W-1:0] resp_data_reg;
  logic              hit_reg;
  logic [CNT_W-1:0]  hit_cnt_reg, miss_cnt_reg;
  logic [SETS-1:0]   valid_reg [WAYS];
  logic [WAY_W-1:0]  fifo_ptr_reg [SETS];
  logic [TAG_W-1:0]  tag_mem [WAYS][SETS];
  logic [DATA_W-1:0] data_mem [WAYS][SETS];

  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic [WAYS-1:0]   valid_vec, hit_vec;
  logic              lookup_hit, all_valid;
  logic [WAY_W-1:0]  hit_way, inv_way, victim_way, line_way;
  logic              line_wr, evict;
  logic [DATA_W-1:0] line_data;

  assign idx = addr_reg[IDX_W-1:0];
  assign tag = addr_reg[ADDR_W-1:IDX_W];

  generate
    for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
      assign valid_vec[gi] = valid_reg[gi][idx];
      assign hit_vec[gi]   = valid_vec[gi] && (tag_mem[gi][idx] == tag);
    end
  endgenerate

  assign lookup_hit = |hit_vec;
  assign all_valid  = &valid_vec;

  // Descending scan so the lowest-numbered matching/invalid way wins.
  always_comb begin
    hit_way = '0;
    inv_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (hit_vec[w])
        hit_way = WAY_W'(w);
      if (!valid_vec[w])
        inv_way = WAY_W'(w);
    end
  end

  assign victim_way = all_valid ? fifo_ptr_reg[idx] : inv_way;

  // Line writes: write hit/allocate during LOOKUP, read-miss fill on the RAM ack.
  assign line_wr   = ((state_reg == LOOKUP) && we_reg) ||
                     ((state_reg == MEM) && bus.mem_ack && !we_reg);
  assign line_way  = ((state_reg == LOOKUP) && lookup_hit) ? hit_way : victim_way;
  assign line_data = (state_reg == LOOKUP) ? wdata_reg : bus.mem_rdata;
  assign evict     = line_wr && all_valid && !((state_reg == LOOKUP) && lookup_hit);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.cpu_req) state_next = LOOKUP;
      LOOKUP:  state_next = (!we_reg && lookup_hit) ? RESP : MEM;
      MEM:     if (bus.mem_ack) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (line_wr) begin
      tag_mem[line_way][idx]  <= tag;
      data_mem[line_way][idx] <= line_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int w = 0; w < WAYS; w++)
        valid_reg[w] <= '0;
      for (int s = 0; s < SETS; s++)
        fifo_ptr_reg[s] <= '0;
    end else if (line_wr) begin
      valid_reg[line_way][idx] <= 1'b1;
      if (evict)
        fifo_ptr_reg[idx] <= fifo_ptr_reg[idx] + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_reg        <= 1'b0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      resp_data_reg <= '0;
      hit_reg       <= 1'b0;
      hit_cnt_reg   <= '0;
      miss_cnt_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: if (bus.cpu_req) begin
          we_reg    <= bus.cpu_we;
          addr_reg  <= bus.cpu_addr;
          wdata_reg <= bus.cpu_wdata;
        end
        LOOKUP: begin
          hit_reg <= lookup_hit;
          if (!we_reg && lookup_hit)
            resp_data_reg <= data_mem[hit_way][idx];
        end
        MEM: if (bus.mem_ack)
          resp_data_reg <= we_reg ? wdata_reg : bus.mem_rdata;
        RESP: begin
          if (hit_reg && (hit_cnt_reg != '1))
            hit_cnt_reg <= hit_cnt_reg + 1'b1;
          if (!hit_reg && (miss_cnt_reg != '1))
            miss_cnt_reg <= miss_cnt_reg + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.cpu_ready  = (state_reg == IDLE);
  assign bus.resp_valid = (state_reg == RESP);
  assign bus.resp_data  = resp_data_reg;
  assign bus.hit        = (state_reg == RESP) && hit_reg;
  assign bus.miss       = (state_reg == RESP) && !hit_reg;
  assign bus.mem_req    = (state_reg == MEM);
  assign bus.mem_we     = (state_reg == MEM) && we_reg;
  assign bus.mem_addr   = addr_reg;
  assign bus.mem_wdata  = wdata_reg;
  assign bus.hit_count  = hit_cnt_reg;
  assign bus.miss_count = miss_cnt_reg;
endmodule

// File: tb/tb_set_assoc_cache_ctrl.sv
// Scoreboard bench for set_assoc_cache_ctrl: queued response/RAM expectations,
// a behavioural RAM with programmable ack delay, and a 2-bit counter build for saturation.
module tb_set_assoc_cache_ctrl;
  localparam int ADDR_W = 6;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct {
    logic [DATA_W-1:0] data;
    bit                hit;
    logic [ADDR_W-1:0] addr;
  } resp_t;

  typedef struct {
    bit                we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  int   ack_delay = 1;
  int   exp_hits = 0;
  int   exp_misses = 0;
  logic [DATA_W-1:0] ram [1 << ADDR_W];
  resp_t resp_q[$];
  mem_t  mem_q[$];

  set_assoc_cache_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  set_assoc_cache_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SETS(4), .WAYS(4), .CNT_W(CNT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int sat_inc(input int v);
    return (v >= CNT_MAX) ? CNT_MAX : v + 1;
  endfunction

  // Response monitor: pops the scoreboard on every completion pulse.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.resp_valid) begin
        resp_t e;
        chk("resp_expected", 32'(resp_q.size() != 0), 32'd1);
        if (resp_q.size() != 0) begin
          e = resp_q.pop_front();
          $display("resp addr=0x%02h data=0x%02h hit=%0b miss=%0b", e.addr, bus.resp_data,
                   bus.hit, bus.miss);
          chk("resp_data", 32'(bus.resp_data), 32'(e.data));
          chk("resp_hit", 32'(bus.hit), 32'(e.hit));
          chk("resp_miss", 32'(bus.miss), 32'(!e.hit));
        end
      end else begin
        chk("idle_hit_miss", 32'({bus.hit, bus.miss}), 32'd0);
      end
    end
  end

  // Behavioural RAM: checks each request against the queued expectation, acks after ack_delay.
  always @(negedge clk) begin
    if (!reset && bus.mem_req) begin
      mem_t e;
      bit   aborted;
      chk("mem_expected", 32'(mem_q.size() != 0), 32'd1);
      e = '{we: 1'b0, addr: bus.mem_addr, wdata: '0};
      if (mem_q.size() != 0) begin
        e = mem_q.pop_front();
        chk("mem_we", 32'(bus.mem_we), 32'(e.we));
        chk("mem_addr", 32'(bus.mem_addr), 32'(e.addr));
        if (e.we)
          chk("mem_wdata", 32'(bus.mem_wdata), 32'(e.wdata));
      end
      aborted = 1'b0;
      for (int i = 1; i < ack_delay; i++) begin
        @(negedge clk);
        if (reset) begin
          aborted = 1'b1;
          break;
        end
      end
      if (!aborted && !reset) begin
        chk("mem_stable", 32'({bus.mem_req, bus.mem_we, bus.mem_addr}),
            32'({1'b1, e.we, e.addr}));
        if (e.we)
          ram[e.addr] = e.wdata;
        else
          bus.mem_rdata = ram[e.addr];
        bus.mem_ack = 1'b1;
        @(negedge clk);
        bus.mem_ack = 1'b0;
      end
    end
  end

  task automatic apply_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    resp_q.delete();
    mem_q.delete();
    exp_hits = 0;
    exp_misses = 0;
    reset = 1'b0;
  endtask

  task automatic do_req(input bit we, input logic [ADDR_W-1:0] addr,
                        input logic [DATA_W-1:0] wdata, input bit exp_hit, input int k);
    int edges;
    int exp_lat;
    ack_delay = k;
    resp_q.push_back('{data: (we ? wdata : ram[addr]), hit: exp_hit, addr: addr});
    if (we || !exp_hit)
      mem_q.push_back('{we: we, addr: addr, wdata: wdata});
    @(negedge clk);
    chk("cpu_ready", 32'(bus.cpu_ready), 32'd1);
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = we;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wdata;
    @(posedge clk);
    #1;
    bus.cpu_req = 1'b0;
    edges = 1;
    while (!bus.resp_valid && edges < 60) begin
      @(posedge clk);
      #1;
      edges++;
    end
    exp_lat = (exp_hit && !we) ? 2 : 2 + k;
    chk("latency", 32'(edges), 32'(exp_lat));
    @(posedge clk);
    #1;
    if (exp_hit)
      exp_hits = sat_inc(exp_hits);
    else
      exp_misses = sat_inc(exp_misses);
    chk("hit_count", 32'(bus.hit_count), 32'(exp_hits));
    chk("miss_count", 32'(bus.miss_count), 32'(exp_misses));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, 32'(bus.cpu_ready), 32'd1);
    chk({tag, "_resp"}, 32'({bus.resp_valid, bus.hit, bus.miss}), 32'd0);
    chk({tag, "_rdata"}, 32'(bus.resp_data), 32'd0);
    chk({tag, "_mem"}, 32'({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata}), 32'd0);
    chk({tag, "_cnt"}, 32'({bus.hit_count, bus.miss_count}), 32'd0);
  endtask

  task automatic abort_read(input logic [ADDR_W-1:0] addr);
    int waited;
    ack_delay = 40;
    @(negedge clk);
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = addr;
    @(posedge clk);
    #1;
    bus.cpu_req = 1'b0;
    waited = 0;
    while (!bus.mem_req && waited < 10) begin
      @(posedge clk);
      #1;
      waited++;
    end
    chk("abort_mem_req_seen", 32'(bus.mem_req), 32'd1);
    #2 reset = 1'b1;
    #1;
    check_reset_outputs("abort");
    $display("abort addr=0x%02h mem_req=%0b after reset", addr, bus.mem_req);
    apply_reset();
  endtask

  initial begin
    for (int a = 0; a < (1 << ADDR_W); a++)
      ram[a] = 8'hA0 ^ 8'(a);
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    apply_reset();
    #1;
    check_reset_outputs("post_reset");

    // Miss with 2-cycle RAM latency, then hit on the same line.
    do_req(1'b0, 6'h05, 8'h00, 1'b0, 2);
    do_req(1'b0, 6'h05, 8'h00, 1'b1, 1);

    // FIFO replacement in set 1 from a clean cache.
    apply_reset();
    do_req(1'b0, 6'h01, 8'h00, 1'b0, 1);
    do_req(1'b0, 6'h05, 8'h00, 1'b0, 1);
    do_req(1'b0, 6'h09, 8'h00, 1'b0, 1);
    do_req(1'b0, 6'h0D, 8'h00, 1'b0, 1);
    do_req(1'b0, 6'h11, 8'h00, 1'b0, 1);
    do_req(1'b0, 6'h01, 8'h00, 1'b0, 1);
    do_req(1'b0, 6'h09, 8'h00, 1'b1, 1);
    do_req(1'b0, 6'h05, 8'h00, 1'b0, 1);
    do_req(1'b0, 6'h0D, 8'h00, 1'b1, 1);

    // Write miss allocates, write hit updates; both write through to RAM.
    do_req(1'b1, 6'h06, 8'h22, 1'b0, 1);
    do_req(1'b0, 6'h06, 8'h00, 1'b1, 1);
    do_req(1'b1, 6'h05, 8'h33, 1'b1, 3);
    do_req(1'b0, 6'h05, 8'h00, 1'b1, 1);

    // Hits past the 2-bit counter limit.
    for (int i = 0; i < 5; i++)
      do_req(1'b0, 6'h05, 8'h00, 1'b1, 1);

    // Reset during an outstanding RAM read; cached lines are then gone.
    abort_read(6'h3F);
    do_req(1'b0, 6'h06, 8'h00, 1'b0, 1);

    repeat (3) @(negedge clk);
    chk("resp_q_drained", 32'(resp_q.size()), 32'd0);
    chk("mem_q_drained", 32'(mem_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/set_assoc_cache_ctrl.md
# set_assoc_cache_ctrl

Parametrised N-way set-associative cache controller. It sits between the CPU-side load/store port and the backing RAM, and is the successor to the fixed 4-set/4-way cache. It adds configurable geometry and a valid-qualified tag compare. It also adds per-set FIFO replacement, a write-through/write-allocate policy, req/ack handshakes on both sides so RAM latency can vary, and saturating hit/miss counters.

## Interface
- ADDR_W, 6, CPU/RAM address width; must exceed log2(SETS)
- DATA_W, 8, data word width (one word per line)
- SETS, 4, number of sets; power of 2, ≥2
- WAYS, 4, associativity; power of 2, ≥2
- CNT_W, 16, width of hit/miss statistics counters
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- cpu_req  in  1  request valid
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  word address; index = low log2(SETS) bits, tag = remaining upper bits
- cpu_wdata  in  DATA_W  write data
- cpu_ready  out  1  controller idle, request accepted this cycle if cpu_req=1
- resp_valid  out  1  one-cycle completion pulse
- resp_data  out  DATA_W  read data (reads) or echoed write data (writes), valid with resp_valid
- hit  out  1  held with resp_valid: lookup hit
- miss  out  1  held with resp_valid: lookup miss
- mem_req  out  1  RAM request, held until mem_ack
- mem_we  out  1  RAM write
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_ack  in  1  RAM completion; for reads mem_rdata valid same cycle
- mem_rdata  in  DATA_W  RAM read data
- hit_count  out  CNT_W  saturating hit counter
- miss_count  out  CNT_W  saturating miss counter

## Operation
- States: IDLE, LOOKUP, MEM, RESP.
- IDLE: cpu_ready=1; on cpu_req latch we/addr/wdata and go to LOOKUP. Any other state: cpu_ready=0; cpu_req is ignored.
- LOOKUP: a way hits when valid[way][set]=1 and its tag equals the latched tag. Invalid ways never hit.
  - Read hit: register the line data, go to RESP.
  - Read miss: go to MEM with mem_we=0.
  - Write (hit or miss): go to MEM with mem_we=1 and mem_wdata=wdata (write-through).
  - At this same edge, a write hit updates its line, and a write miss allocates a victim way (tag, data=wdata, valid=1).
- Victim selection: the lowest-numbered invalid way in the set. If all ways are valid, use the set's FIFO pointer fifo_ptr[set] and then increment it modulo WAYS. The pointer advances only on eviction of a valid line. Pointers are per set.
- MEM: mem_req=1, mem_addr=latched addr; all mem_* outputs stay stable until mem_ack. On the edge where mem_ack=1:
  - Read miss: allocate the victim with mem_rdata and register resp_data=mem_rdata.
  - Write: resp_data=wdata.
  - Then go to RESP.
- RESP: resp_valid=1, hit/miss reflect the lookup result. Increment hit_count or miss_count by 1, saturating at 2^CNT_W−1. Return to IDLE.
- mem_ack outside MEM is ignored.

## Timing
- Reset values: cpu_ready=1, resp_valid=0, hit=0, miss=0, resp_data=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, counters=0, all valid bits=0, all fifo_ptr=0, state=IDLE. Tag/data arrays are not reset.
- Accept at edge E0. Read hit: resp_valid high in the cycle after E1 (3 cycles from request to IDLE).
- Miss or write: mem_req rises after E1. If mem_ack arrives k cycles after mem_req rises (k≥1), resp_valid is high for one cycle after the ack edge.
- Back-to-back: a new request is accepted in the IDLE cycle following RESP. There are no outstanding requests and no pipelining.
- Reset asserted mid-transaction aborts it: mem_req drops asynchronously, no partial line is written, and resp_valid is not issued.
- hit and miss are never both 1. Both are 0 whenever resp_valid=0.

## Test plan
- Reset, then read 0x05 with mem_ack 2 cycles after mem_req and mem_rdata=0xA5 -> miss=1, resp_data=0xA5, miss_count=1. Read 0x05 again -> hit=1, resp_data=0xA5, no mem_req, response 2 edges after acceptance.
- Fill set 1 with reads 0x01,0x05,0x09,0x0D (ways 0–3), then read 0x11 -> miss, way 0 evicted. Re-read 0x01 -> miss, evicts way 1 (0x05). Read 0x09 -> hit.
- Write 0x22 to 0x06 (miss) -> mem_req with mem_we=1, mem_addr=0x06, mem_wdata=0x22. After ack, read 0x06 -> hit, resp_data=0x22.
- Write 0x33 to cached 0x05 -> hit=1, RAM write issued. Read 0x05 -> hit, 0x33.
- Assert reset while mem_req=1 -> mem_req=0 immediately, all outputs at reset values. Read of a previously cached address -> miss.
- Preload hit_count near saturation (CNT_W=2 build): 5 hits -> hit_count saturates at 3.
